mux_arb: RTL

Parametrised N-channel, WIDTH-bit registered multiplexer with per-channel valid/ready handshakes, succeeding the fixed 2-/4-way combinational muxes. It selects one input channel per transfer, either by an external select (fixed mode) or by round-robin arbitration, and presents the result through a one-deep output register. It sits wherever several producers share a single downstream consumer.

---
 rtl/mux_arb.sv | 115 +++++++++++
 1 files changed

// File: rtl/mux_arb.sv
// mux_arb: N-channel, WIDTH-bit registered multiplexer with per-channel
// valid/ready handshakes. A channel is chosen each cycle either by an
// external select (mode=0) or by round-robin arbitration (mode=1). The
// chosen word is captured into a one-deep output register.
module mux_arb #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned N     = 4,
  parameter int unsigned SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  input  logic                 out_ready
);

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q,  out_data_d;
  logic [SELW-1:0]   out_chan_q,  out_chan_d;
  logic [SELW-1:0]   ptr_q,       ptr_d;

  logic              load;
  logic              xfer;
  logic              grant_vld;
  logic [SELW-1:0]   grant_idx;
  logic [WIDTH-1:0]  grant_data;
  int unsigned       scan_idx;

  // The output register can take a new word when empty or being drained.
  assign load = !out_valid_q || out_ready;
  assign xfer = load && grant_vld;

  // Channel choice: fixed select (out-of-range sel grants nothing) or a
  // round-robin scan starting at ptr and wrapping modulo N.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    if (!mode) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (sel == SELW'(i) && in_valid[i]) begin
          grant_vld = 1'b1;
          grant_idx = SELW'(i);
        end
      end
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        scan_idx = 32'(ptr_q) + k;
        if (scan_idx >= N) scan_idx = scan_idx - N;
        if (!grant_vld && in_valid[scan_idx]) begin
          grant_vld = 1'b1;
          grant_idx = SELW'(scan_idx);
        end
      end
    end
  end

  // Data select for the granted channel.
  always_comb begin
    grant_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_idx == SELW'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Ready goes only to the granted channel, and only when a load can occur.
  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < N; i++) begin
      in_ready[i] = xfer && (grant_idx == SELW'(i));
    end
  end

  // Next state: refill on transfer, otherwise drain if the consumer took it.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_chan_d  = grant_idx;
      if (mode) ptr_d = (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + SELW'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule
